vga_fb_arbiter: RTL

Shares one single-port synchronous framebuffer RAM between VGA scan-out and a pixel writer, such as a drawing engine or UART loader. It sits between the sync/counter generator and the RAM, and takes the column/row counts from the sync generator. Scan-out reads are scheduled with absolute priority, and the framebuffer is upscaled by 2^SHIFT in both axes. Writes are granted only on cycles that carry no display read.

---
 rtl/vga_fb_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out reads have absolute priority, writer uses free cycles.
// Optional VGA_FB_WR_FIFO_EN inserts a 4-entry write FIFO in front of the RAM port.
module vga_fb_arbiter #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int SHIFT       = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 12
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [11:0]       i_Col_Count,
    input  logic [11:0]       i_Row_Count,
    input  logic              i_Wr_Valid,
    output logic              o_Wr_Ready,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [DATA_W-1:0] i_Wr_Data,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic              o_Mem_We,
    output logic [DATA_W-1:0] o_Mem_Wr_Data,
    input  logic [DATA_W-1:0] i_Mem_Rd_Data,
    output logic [DATA_W-1:0] o_Pixel,
    output logic              o_Pixel_Active,
    output logic              o_Frame_Done
);

    localparam logic [11:0]       LAST_COL = 12'(TOTAL_COLS - 1);
    localparam logic [11:0]       LAST_ROW = 12'(TOTAL_ROWS - 1);
    localparam logic [11:0]       ACT_COLS = 12'(ACTIVE_COLS);
    localparam logic [11:0]       ACT_ROWS = 12'(ACTIVE_ROWS);
    localparam logic [11:0]       LOW_MASK = 12'((1 << SHIFT) - 1);
    localparam logic [ADDR_W-1:0] FB_COLS  = ADDR_W'(ACTIVE_COLS >> SHIFT);

    logic              active;
    logic              display_slot;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        active_pipe;
    logic              slot_d1;
    logic              slot_d2;
    logic [DATA_W-1:0] pixel_hold;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_data;

    assign active       = (i_Col_Count < ACT_COLS) && (i_Row_Count < ACT_ROWS);
    assign display_slot = active && ((i_Col_Count & LOW_MASK) == 12'd0);
    assign rd_addr      = line_base + ADDR_W'(i_Col_Count >> SHIFT);

    // Line base advances once per replicated group of rows; the frame clear wins over the increment.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            line_base <= '0;
        end else if (i_Col_Count == LAST_COL) begin
            if (i_Row_Count == LAST_ROW)
                line_base <= '0;
            else if ((i_Row_Count < ACT_ROWS) && ((i_Row_Count & LOW_MASK) == LOW_MASK))
                line_base <= line_base + FB_COLS;
        end
    end

`ifdef VGA_FB_WR_FIFO_EN
    logic [ADDR_W+DATA_W-1:0] fifo_mem [4];
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [1:0]               wr_ptr;
    logic [1:0]               rd_ptr;
    logic [2:0]               count;
    logic                     push;
    logic                     pop;

    assign o_Wr_Ready  = i_Rst_L && (count != 3'd4);
    assign push        = i_Wr_Valid && o_Wr_Ready;
    assign pop         = !display_slot && (count != 3'd0);
    assign fifo_head   = fifo_mem[rd_ptr];
    assign issue_valid = pop;
    assign issue_addr  = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign issue_data  = fifo_head[DATA_W-1:0];

    always_ff @(posedge i_Clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {i_Wr_Addr, i_Wr_Data};
    end

    // Push and pop may coincide except when full, where ready is already low.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end
`else
    assign o_Wr_Ready  = i_Rst_L && !display_slot;
    assign issue_valid = i_Wr_Valid && o_Wr_Ready;
    assign issue_addr  = i_Wr_Addr;
    assign issue_data  = i_Wr_Data;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Mem_Addr    <= '0;
            o_Mem_We      <= 1'b0;
            o_Mem_Wr_Data <= '0;
        end else if (display_slot) begin
            o_Mem_Addr <= rd_addr;
            o_Mem_We   <= 1'b0;
        end else if (issue_valid) begin
            o_Mem_Addr    <= issue_addr;
            o_Mem_Wr_Data <= issue_data;
            o_Mem_We      <= 1'b1;
        end else begin
            o_Mem_We <= 1'b0;
        end
    end

    // Read data arrives two cycles after its slot; holding it between slots replicates the pixel.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            active_pipe  <= '0;
            slot_d1      <= 1'b0;
            slot_d2      <= 1'b0;
            pixel_hold   <= '0;
            o_Frame_Done <= 1'b0;
        end else begin
            active_pipe  <= {active_pipe[1:0], active};
            slot_d1      <= display_slot;
            slot_d2      <= slot_d1;
            if (slot_d2)
                pixel_hold <= i_Mem_Rd_Data;
            o_Frame_Done <= (i_Col_Count == 12'd0) && (i_Row_Count == ACT_ROWS);
        end
    end

    assign o_Pixel_Active = active_pipe[2];
    assign o_Pixel        = active_pipe[2] ? pixel_hold : '0;

endmodule
